// File: rtl/io_sequencer.sv
// CPMath I/O sequencer: serves IN (switches -> stdin) and OUT
// (binary -> BCD -> 7-seg) requests one at a time for the control unit.
module io_sequencer #(
  parameter int DATA_W   = 16,
  parameter int CONV_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_req,
  input  logic              out_req,
  input  logic [DATA_W-1:0] out_data,
  input  logic [DATA_W-1:0] switch,
  input  logic              confirm,
  output logic [DATA_W-1:0] stdin,
  output logic              in_done,
  output logic              out_done,
  output logic              busy,
  output logic              ovf,
  output logic [6:0]        display0,
  output logic [6:0]        display1,
  output logic [6:0]        display2
);

  localparam int CW    = $clog2(CONV_CYC);
  localparam int BCD_W = 20;

  typedef enum logic [1:0] {
    IDLE,
    IN_WAIT,
    OUT_CONV,
    OUT_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  shreg;
  logic [BCD_W-1:0]   bcd, bcd_adj;
  logic [BCD_W+DATA_W-1:0] step;
  logic [CW-1:0]      cnt;
  logic               sync1, sync2, prev;
  logic               conf_rise;

  function automatic logic [6:0] seg(input logic [3:0] d);
    unique case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  assign conf_rise = sync2 & ~prev;
  assign busy      = (state != IDLE);

  // One double-dabble step: add 3 to every nibble >= 5, then shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    step = {bcd_adj, shreg} << 1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (out_req)     state_nxt = OUT_CONV;
        else if (in_req) state_nxt = IN_WAIT;
      end
      IN_WAIT: begin
        if (conf_rise) state_nxt = IDLE;
      end
      OUT_CONV: begin
        if (cnt == CW'(CONV_CYC - 1)) state_nxt = OUT_DONE;
      end
      OUT_DONE: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      state <= state_nxt;
      sync1 <= confirm;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg    <= '0;
      bcd      <= '0;
      cnt      <= '0;
      stdin    <= '0;
      in_done  <= 1'b0;
      out_done <= 1'b0;
      ovf      <= 1'b0;
      display0 <= 7'b1000000;
      display1 <= 7'b1000000;
      display2 <= 7'b1000000;
    end else begin
      in_done  <= 1'b0;
      out_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (out_req) begin
            shreg <= out_data;
            bcd   <= '0;
            cnt   <= '0;
          end
        end
        IN_WAIT: begin
          if (conf_rise) begin
            stdin   <= switch;
            in_done <= 1'b1;
          end
        end
        OUT_CONV: begin
          bcd   <= step[BCD_W+DATA_W-1:DATA_W];
          shreg <= step[DATA_W-1:0];
          cnt   <= cnt + 1'b1;
        end
        OUT_DONE: begin
          display0 <= seg(bcd[3:0]);
          display1 <= seg(bcd[7:4]);
          display2 <= seg(bcd[11:8]);
          ovf      <= (bcd[19:12] != '0);
          out_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
